// File: rtl/mig_seq_evaluator_if.sv
// Bus bundle for the MIG sequential evaluator: program port, run request and result.
//
// Handshake: a run is requested by a single-cycle start pulse and is accepted
// on a rising edge only while busy is low; num_gates, out_sel and x are
// sampled on that same edge. busy stays high until the edge that raises done.
// done is a one-cycle pulse, and out/err are valid with it and held until the
// next done. A start in the done cycle is accepted. cfg_we writes the program
// on its edge only while busy is low.
interface mig_seq_evaluator_if #(
  parameter int NUM_IN = 7,
  parameter int SEL_W  = 5,
  parameter int GA_W   = 4
);
  logic                     cfg_we;
  logic [GA_W-1:0]          cfg_addr;
  logic [3*(SEL_W+1)-1:0]   cfg_data;
  logic                     start;
  logic [GA_W:0]            num_gates;
  logic [SEL_W-1:0]         out_sel;
  logic [NUM_IN-1:0]        x;
  logic                     busy;
  logic                     done;
  logic                     out;
  logic                     err;

  modport master (
    output cfg_we, cfg_addr, cfg_data, start, num_gates, out_sel, x,
    input  busy, done, out, err
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, start, num_gates, out_sel, x,
    output busy, done, out, err
  );
endinterface

// File: rtl/mig_seq_evaluator.sv
// Time-shared MIG evaluator: one MAJ3 unit walks a stored gate program, one
// gate per cycle, and returns the value of a selected node.
// Node map: 0 = const 0, 1..NUM_IN = x, NUM_IN+1+g = gate g.
module mig_seq_evaluator #(
  parameter int NUM_IN    = 7,
  parameter int MAX_GATES = 16,
  parameter int SEL_W     = 5,
  parameter int GA_W      = 4
) (
  input  logic               clk,
  input  logic               rst,
  mig_seq_evaluator_if.slave bus,
  output logic [1:0]         dbg_state
);

  localparam int NODES = 1 + NUM_IN + MAX_GATES;
  localparam int CW    = SEL_W + 1;
  localparam int CFG_W = 3 * CW;

  localparam logic [SEL_W-1:0] GATE_BASE = SEL_W'(NUM_IN + 1);
  localparam logic [SEL_W:0]   OUT_BASE  = (SEL_W+1)'(NUM_IN + 1);
  localparam logic [GA_W:0]    MAX_NG    = (GA_W+1)'(MAX_GATES);
  localparam logic [GA_W:0]    NG_ONE    = (GA_W+1)'(1);
  localparam logic [GA_W-1:0]  G_ONE     = GA_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVAL   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t              state;
  logic [CFG_W-1:0]    prog [MAX_GATES];
  logic [NODES-1:0]    node;
  logic [GA_W-1:0]     g;
  logic [GA_W:0]       ng_q;
  logic [SEL_W-1:0]    sel_q;
  logic                err_acc;
  logic                bad_cnt;

  logic [CFG_W-1:0]    cur;
  logic [SEL_W-1:0]    gate_node;
  logic                inv_a, inv_b, inv_c;
  logic [SEL_W-1:0]    sel_a, sel_b, sel_c;
  logic                ok_a, ok_b, ok_c;
  logic                op_a, op_b, op_c;
  logic                maj;
  logic                op_err;
  logic                last_gate;
  logic                out_ok;
  logic                ng_ok;

  assign dbg_state = state;

  // Decode the current gate and form its MAJ3 value; illegal operands read 0.
  always_comb begin
    cur       = prog[g];
    gate_node = GATE_BASE + SEL_W'(g);
    inv_a     = cur[3*CW-1];
    sel_a     = cur[3*CW-2 -: SEL_W];
    inv_b     = cur[2*CW-1];
    sel_b     = cur[2*CW-2 -: SEL_W];
    inv_c     = cur[CW-1];
    sel_c     = cur[CW-2 -: SEL_W];
    // Only strictly earlier nodes are legal, which also rules out
    // self-reference, forward reference and out-of-range selectors.
    ok_a      = sel_a < gate_node;
    ok_b      = sel_b < gate_node;
    ok_c      = sel_c < gate_node;
    op_a      = (ok_a ? node[sel_a] : 1'b0) ^ inv_a;
    op_b      = (ok_b ? node[sel_b] : 1'b0) ^ inv_b;
    op_c      = (ok_c ? node[sel_c] : 1'b0) ^ inv_c;
    maj       = (op_a & op_b) | (op_a & op_c) | (op_b & op_c);
    op_err    = ~(ok_a & ok_b & ok_c);
    last_gate = ({1'b0, g} + NG_ONE) == ng_q;
    out_ok    = {1'b0, sel_q} < (OUT_BASE + (SEL_W+1)'(ng_q));
    ng_ok     = (bus.num_gates != '0) && (bus.num_gates <= MAX_NG);
  end

  // Program store: writable only while the evaluator is idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_GATES; i++) prog[i] <= '0;
    end else if (bus.cfg_we && state == IDLE) begin
      prog[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  // Control FSM with registered busy/done/out/err and the node value store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.out  <= 1'b0;
      bus.err  <= 1'b0;
      node     <= '0;
      g        <= '0;
      ng_q     <= '0;
      sel_q    <= '0;
      err_acc  <= 1'b0;
      bad_cnt  <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            ng_q             <= bus.num_gates;
            sel_q            <= bus.out_sel;
            node[NUM_IN:1]   <= bus.x;
            g                <= '0;
            bus.busy         <= 1'b1;
            if (!ng_ok) begin
              // Nothing to evaluate: report the error without touching out.
              err_acc <= 1'b1;
              bad_cnt <= 1'b1;
              state   <= FINISH;
            end else begin
              err_acc <= 1'b0;
              bad_cnt <= 1'b0;
              state   <= EVAL;
            end
          end
        end
        EVAL: begin
          node[gate_node] <= maj;
          if (op_err) err_acc <= 1'b1;
          g <= g + G_ONE;
          if (last_gate) state <= FINISH;
        end
        FINISH: begin
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
          if (bad_cnt) begin
            bus.err <= 1'b1;
          end else if (out_ok) begin
            bus.out <= node[sel_q];
            bus.err <= err_acc;
          end else begin
            bus.err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
